// File: rtl/sf_camera_writer_pkg.sv
// Shared definitions for the camera pixel-bus writer: FSM state encoding,
// the byte order on the pixel bus (shared with the camera reader), and a
// helper for the per-frame line count.
package sf_camera_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VPORCH   = 3'd1,
    ST_WAIT_BUF = 3'd2,
    ST_PREFETCH = 3'd3,
    ST_LINE     = 3'd4,
    ST_HBLANK   = 3'd5,
    ST_VBLANK   = 3'd6
  } wr_state_e;

  // Word bytes leave the bus most significant byte first (data[31:24] first).
  localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;

  // A requested line count of 0 still sends a single line.
  function automatic logic [15:0] frame_lines(input logic [15:0] req);
    return (req == 16'd0) ? 16'd1 : req;
  endfunction

endpackage

// File: rtl/sf_word_serializer.sv
// Loads one 32-bit word and presents its four bytes, one per advance, in the
// shared byte order. The presented byte is a register slice, so it can drive
// the pixel bus directly; clearing forces the bus byte to zero.
module sf_word_serializer
  import sf_camera_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        next_i,
  input  logic        clr_i,
  input  logic [31:0] word_i,
  output logic [7:0]  byte_o,
  output logic [1:0]  idx_o,
  output logic        last_o
);

  logic [31:0] sh_q, sh_d;
  logic [1:0]  idx_q, idx_d;

  // Next shift-register contents: clear wins, then load, then advance one byte.
  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (clr_i) begin
      sh_d  = 32'd0;
      idx_d = 2'd0;
    end else if (load_i) begin
      sh_d  = word_i;
      idx_d = 2'd0;
    end else if (next_i) begin
      sh_d  = BYTE_ORDER_MSB_FIRST ? {sh_q[23:0], 8'h00} : {8'h00, sh_q[31:8]};
      idx_d = idx_q + 2'd1;
    end
  end

  // Shift register and byte index.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= 32'd0;
      idx_q <= 2'd0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

  assign byte_o = BYTE_ORDER_MSB_FIRST ? sh_q[31:24] : sh_q[7:0];
  assign idx_o  = idx_q;
  assign last_o = (idx_q == 2'd3);

endmodule

// File: rtl/sf_camera_writer.sv
// Camera-format pixel bus transmitter. Pulls one ping-pong FIFO buffer per
// video line and sends it as bytes framed by vsync (whole frame) and hsync
// (active bytes only).
// Optional build macro SF_CAMERA_WRITER_TEST_PATTERN_EN adds a test-pattern
// source (incrementing bytes) that bypasses the FIFO.
//
// FIFO handshake: activate is held for the whole buffer; data for the first
// word is valid the cycle after activate is first seen, and each strobe pops
// one word so the next one is valid the cycle after the strobe. The strobe is
// issued alongside byte 2 of the current word so the next word has settled
// when byte 3 is on the bus, giving bubble-free lines.
module sf_camera_writer
  import sf_camera_writer_pkg::*;
#(
  parameter int HBLANK_CYCLES = 8,
  parameter int VPORCH_CYCLES = 16,
  parameter int VBLANK_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [15:0] i_lines_per_frame,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic [31:0] o_line_count,
  output logic [31:0] o_frame_count,
  output logic [31:0] o_stall_count,
  input  logic        i_rfifo_ready,
  output logic        o_rfifo_activate,
  output logic        o_rfifo_strobe,
  input  logic [31:0] i_rfifo_data,
  input  logic [23:0] i_rfifo_size,
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
  input  logic        i_test_pattern,
  input  logic [23:0] i_test_line_words,
`endif
  output logic        o_vsync,
  output logic        o_hsync,
  output logic [7:0]  o_pix_data,
  output wr_state_e   o_dbg_state
);

  wr_state_e   state_q;
  logic [31:0] cnt_q;
  logic [15:0] lines_left_q;
  logic [23:0] size_q, words_left_q;
  logic        vsync_q, hsync_q, busy_q, done_q, act_q, strobe_q;
  logic [31:0] line_cnt_q, frame_cnt_q, stall_cnt_q;

  logic        ser_load, ser_next, ser_clr, ser_last;
  logic [1:0]  ser_idx;
  logic [7:0]  ser_byte;
  logic [31:0] load_word;
  logic        byte_slot;

`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
  logic        tp_q;
  logic [7:0]  tp_cnt_q;
`endif

  // A new byte slot opens when no word is on the bus or its last byte is out.
  assign byte_slot = (state_q == ST_LINE) && (!hsync_q || ser_last);

  // Serializer control and the word source for the next load.
  always_comb begin
    ser_load  = byte_slot && (words_left_q != 24'd0);
    ser_clr   = byte_slot && (words_left_q == 24'd0);
    ser_next  = (state_q == ST_LINE) && hsync_q && !ser_last;
    load_word = i_rfifo_data;
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
    if (tp_q) load_word = {tp_cnt_q, tp_cnt_q + 8'd1, tp_cnt_q + 8'd2, tp_cnt_q + 8'd3};
`endif
  end

  sf_word_serializer u_ser (
    .clk    (clk),
    .rst    (rst),
    .load_i (ser_load),
    .next_i (ser_next),
    .clr_i  (ser_clr),
    .word_i (load_word),
    .byte_o (ser_byte),
    .idx_o  (ser_idx),
    .last_o (ser_last)
  );

  // Frame/line sequencer with registered sync, FIFO control and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 32'd0;
      lines_left_q <= 16'd0;
      size_q       <= 24'd0;
      words_left_q <= 24'd0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      act_q        <= 1'b0;
      strobe_q     <= 1'b0;
      line_cnt_q   <= 32'd0;
      frame_cnt_q  <= 32'd0;
      stall_cnt_q  <= 32'd0;
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
      tp_q         <= 1'b0;
      tp_cnt_q     <= 8'd0;
`endif
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_enable) begin
            lines_left_q <= frame_lines(i_lines_per_frame);
            vsync_q      <= 1'b1;
            busy_q       <= 1'b1;
            cnt_q        <= 32'd0;
            state_q      <= ST_VPORCH;
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
            tp_q         <= i_test_pattern;
            tp_cnt_q     <= 8'd0;
`endif
          end
        end
        ST_VPORCH: begin
          if (cnt_q + 32'd1 >= 32'(VPORCH_CYCLES)) begin
            cnt_q   <= 32'd0;
            state_q <= ST_WAIT_BUF;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_WAIT_BUF: begin
          stall_cnt_q <= stall_cnt_q + 32'd1;
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
          if (tp_q) begin
            size_q  <= i_test_line_words;
            state_q <= ST_PREFETCH;
          end else
`endif
          if (i_rfifo_ready && !act_q) begin
            act_q   <= 1'b1;
            size_q  <= i_rfifo_size;
            state_q <= ST_PREFETCH;
          end
        end
        ST_PREFETCH: begin
          // An empty buffer is handed back without producing a line.
          if (size_q == 24'd0) begin
            act_q   <= 1'b0;
            state_q <= ST_WAIT_BUF;
          end else begin
            words_left_q <= size_q;
            state_q      <= ST_LINE;
          end
        end
        ST_LINE: begin
          if (byte_slot) begin
            if (words_left_q != 24'd0) begin
              hsync_q      <= 1'b1;
              words_left_q <= words_left_q - 24'd1;
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
              if (tp_q) tp_cnt_q <= tp_cnt_q + 8'd4;
`endif
            end else begin
              hsync_q      <= 1'b0;
              act_q        <= 1'b0;
              line_cnt_q   <= line_cnt_q + 32'd1;
              lines_left_q <= lines_left_q - 16'd1;
              cnt_q        <= 32'd0;
              state_q      <= ST_HBLANK;
            end
          end else if (ser_idx == 2'd1) begin
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
            strobe_q <= !tp_q;
`else
            strobe_q <= 1'b1;
`endif
          end
        end
        ST_HBLANK: begin
          if (cnt_q + 32'd1 >= 32'(HBLANK_CYCLES)) begin
            cnt_q <= 32'd0;
            if (lines_left_q != 16'd0) begin
              state_q <= ST_WAIT_BUF;
            end else begin
              vsync_q <= 1'b0;
              state_q <= ST_VBLANK;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_VBLANK: begin
          if (cnt_q + 32'd1 >= 32'(VBLANK_CYCLES)) begin
            cnt_q       <= 32'd0;
            done_q      <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 32'd1;
            if (i_enable) begin
              lines_left_q <= frame_lines(i_lines_per_frame);
              vsync_q      <= 1'b1;
              state_q      <= ST_VPORCH;
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
              tp_q         <= i_test_pattern;
              tp_cnt_q     <= 8'd0;
`endif
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy           = busy_q;
  assign o_frame_done     = done_q;
  assign o_line_count     = line_cnt_q;
  assign o_frame_count    = frame_cnt_q;
  assign o_stall_count    = stall_cnt_q;
  assign o_rfifo_activate = act_q;
  assign o_rfifo_strobe   = strobe_q;
  assign o_vsync          = vsync_q;
  assign o_hsync          = hsync_q;
  assign o_pix_data       = ser_byte;
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_sf_camera_writer.sv
// Directed bench for sf_camera_writer with a ping-pong read-FIFO model and a
// pixel-bus monitor. Buffers are described by a small table; expected bytes
// are hand-listed words queued MSB byte first.
module tb_sf_camera_writer;
  import sf_camera_writer_pkg::*;

  localparam int HB = 8;
  localparam int BUDGET = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en = 1'b0;
  logic [15:0] lpf = 16'd1;
  logic        busy, frame_done;
  logic [31:0] line_cnt, frame_cnt, stall_cnt;
  logic        fifo_ready = 1'b0;
  logic        act, strobe;
  logic [31:0] fifo_data = 32'hBAD0BAD0;
  logic [23:0] fifo_size = 24'd0;
  logic        vsync, hsync;
  logic [7:0]  pix;
  wr_state_e   dbg;
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
  logic        tp = 1'b0;
  logic [23:0] tp_words = 24'd0;
`endif

  sf_camera_writer dut (
    .clk               (clk),
    .rst               (rst),
    .i_enable          (en),
    .i_lines_per_frame (lpf),
    .o_busy            (busy),
    .o_frame_done      (frame_done),
    .o_line_count      (line_cnt),
    .o_frame_count     (frame_cnt),
    .o_stall_count     (stall_cnt),
    .i_rfifo_ready     (fifo_ready),
    .o_rfifo_activate  (act),
    .o_rfifo_strobe    (strobe),
    .i_rfifo_data      (fifo_data),
    .i_rfifo_size      (fifo_size),
`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
    .i_test_pattern    (tp),
    .i_test_line_words (tp_words),
`endif
    .o_vsync           (vsync),
    .o_hsync           (hsync),
    .o_pix_data        (pix),
    .o_dbg_state       (dbg)
  );

  // ---------------- read-FIFO model ----------------
  int          nbuf = 0, nxt = 0, cur = 0, ptr = 0;
  int          bsize [4];
  logic [31:0] bword [4][2];
  logic [31:0] pend = 32'hBAD0BAD0;
  bit          act_seen = 1'b0;
  bit          hold = 1'b0;
  int          act_rises = 0;

  // Data trails activate/strobe by one cycle; ready advertises the next buffer.
  always @(negedge clk) begin
    fifo_data = pend;
    if (act) begin
      if (!act_seen) begin
        act_seen = 1'b1;
        cur = nxt;
        nxt++;
        ptr = 0;
        act_rises++;
      end else if (strobe) begin
        ptr++;
      end
      pend = (cur < 4 && ptr < bsize[cur % 4] && ptr < 2) ? bword[cur % 4][ptr % 2] : 32'hBAD0BAD0;
    end else begin
      act_seen = 1'b0;
      pend = 32'hBAD0BAD0;
    end
    fifo_ready = !hold && (nxt < nbuf);
    fifo_size  = (nxt < nbuf) ? 24'(bsize[nxt % 4]) : 24'd0;
  end

  // ---------------- pixel-bus monitor ----------------
  logic [7:0] cap_q[$];
  int         runs_q[$];
  int         run = 0, gap = 0, min_gap = 9999, strobes = 0, done_cnt = 0, nonzero_pix = 0;
  bit         prev_h = 1'b0, had_line = 1'b0;

  always @(negedge clk) begin
    if (hsync) begin
      if (!prev_h && had_line && gap < min_gap) min_gap = gap;
      cap_q.push_back(pix);
      run++;
    end else begin
      if (prev_h) begin
        runs_q.push_back(run);
        run = 0;
        gap = 0;
        had_line = 1'b1;
      end
      gap++;
      if (pix !== 8'h00) nonzero_pix++;
    end
    prev_h = hsync;
    if (strobe) strobes++;
    if (frame_done) done_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) check($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    cap_q.delete();
    runs_q.delete();
    exp_q.delete();
    run = 0; gap = 0; min_gap = 9999; strobes = 0; done_cnt = 0;
    nonzero_pix = 0; had_line = 1'b0; act_rises = 0;
  endtask

  task automatic set_buf(input int i, input int sz, input logic [31:0] w0, input logic [31:0] w1);
    bsize[i]    = sz;
    bword[i][0] = w0;
    bword[i][1] = w1;
  endtask

  task automatic load_fifo(input int n);
    nbuf = n;
    nxt  = 0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_hsync(input string tag, input logic level);
    int n = 0;
    while (hsync !== level && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < BUDGET), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s0, st0;

    // Reset state
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_vsync", 32'(vsync), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd0);
    check("rst_act", 32'(act), 32'd0);
    check("rst_strobe", 32'(strobe), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg), 32'(ST_IDLE));
    check("rst_lines", line_cnt, 32'd0);

    // Test 1: two lines of two words each
    clear_stats();
    set_buf(0, 2, 32'h01020304, 32'h05060708);
    set_buf(1, 2, 32'hA0B0C0D0, 32'hE0F00102);
    load_fifo(2);
    lpf = 16'd2;
    en = 1'b1;
    @(negedge clk);
    check("t1_vsync_up", 32'(vsync), 32'd1);
    check("t1_hsync_porch", 32'(hsync), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    en = 1'b0;
    wait_done("t1_done_wait", 1);
    push_word(32'h01020304); push_word(32'h05060708);
    push_word(32'hA0B0C0D0); push_word(32'hE0F00102);
    compare_bytes("t1");
    check("t1_runs", 32'(runs_q.size()), 32'd2);
    if (runs_q.size() == 2) begin
      check("t1_run0", 32'(runs_q[0]), 32'd8);
      check("t1_run1", 32'(runs_q[1]), 32'd8);
    end
    check("t1_gap_min", 32'(min_gap >= HB), 32'd1);
    check("t1_frame_cnt", frame_cnt, 32'd1);
    check("t1_line_cnt", line_cnt, 32'd2);
    check("t1_stall", stall_cnt, 32'd2);
    check("t1_strobes", 32'(strobes), 32'd4);
    wait_cycles(3);
    check("t1_done_once", 32'(done_cnt), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_pix_quiet", 32'(nonzero_pix), 32'd0);

    // Test 2: starve the FIFO for a while before line 2
    clear_stats();
    set_buf(0, 2, 32'h10203040, 32'h50607080);
    set_buf(1, 2, 32'h0A0B0C0D, 32'h0E0F1011);
    load_fifo(2);
    lpf = 16'd2;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_hsync("t2_line1_start", 1'b1);
    hold = 1'b1;
    wait_hsync("t2_line1_end", 1'b0);
    s0 = stall_cnt;
    st0 = strobes;
    wait_cycles(30);
    check("t2_no_line2", 32'(cap_q.size()), 32'd8);
    check("t2_hsync_low", 32'(hsync), 32'd0);
    check("t2_no_strobe", 32'(strobes - st0), 32'd0);
    check("t2_stall_grow", 32'((stall_cnt - 32'(s0)) >= 32'd20), 32'd1);
    hold = 1'b0;
    wait_done("t2_done_wait", 1);
    push_word(32'h10203040); push_word(32'h50607080);
    push_word(32'h0A0B0C0D); push_word(32'h0E0F1011);
    compare_bytes("t2");
    check("t2_frame_cnt", frame_cnt, 32'd2);
    check("t2_line_cnt", line_cnt, 32'd4);

    // Test 3: empty buffer then a one-word buffer; lines=0 means one line
    clear_stats();
    set_buf(0, 0, 32'h0, 32'h0);
    set_buf(1, 1, 32'hDEADBEEF, 32'h0);
    load_fifo(2);
    lpf = 16'd0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done("t3_done_wait", 1);
    push_word(32'hDEADBEEF);
    compare_bytes("t3");
    check("t3_runs", 32'(runs_q.size()), 32'd1);
    check("t3_act_rises", 32'(act_rises), 32'd2);
    check("t3_line_cnt", line_cnt, 32'd5);
    check("t3_frame_cnt", frame_cnt, 32'd3);
    check("t3_pix_quiet", 32'(nonzero_pix), 32'd0);

    // Test 4: drop enable in the middle of line 1 of 3
    clear_stats();
    set_buf(0, 1, 32'h11223344, 32'h0);
    set_buf(1, 1, 32'h55667788, 32'h0);
    set_buf(2, 1, 32'h99AABBCC, 32'h0);
    load_fifo(3);
    lpf = 16'd3;
    en = 1'b1;
    wait_hsync("t4_line1_start", 1'b1);
    wait_cycles(2);
    en = 1'b0;
    wait_done("t4_done_wait", 1);
    wait_cycles(3);
    push_word(32'h11223344); push_word(32'h55667788); push_word(32'h99AABBCC);
    compare_bytes("t4");
    check("t4_runs", 32'(runs_q.size()), 32'd3);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_vsync", 32'(vsync), 32'd0);
    check("t4_line_cnt", line_cnt, 32'd8);
    check("t4_frame_cnt", frame_cnt, 32'd4);
    wait_cycles(40);
    check("t4_stay_idle", 32'(busy), 32'd0);
    check("t4_done_once", 32'(done_cnt), 32'd1);

`ifdef SF_CAMERA_WRITER_TEST_PATTERN_EN
    // Test 6: internal test pattern, FIFO untouched
    clear_stats();
    load_fifo(0);
    tp = 1'b1;
    tp_words = 24'd1;
    lpf = 16'd2;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    tp = 1'b0;
    wait_done("t6_done_wait", 1);
    push_word(32'h00010203); push_word(32'h04050607);
    compare_bytes("t6");
    check("t6_no_activate", 32'(act_rises), 32'd0);
    check("t6_no_strobe", 32'(strobes), 32'd0);
`endif

    // Test 5: reset during the third byte of a line
    clear_stats();
    set_buf(0, 2, 32'h11223344, 32'h55667788);
    load_fifo(1);
    lpf = 16'd1;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_hsync("t5_line_start", 1'b1);
    wait_cycles(2);
    check("t5_byte2", 32'(pix), 32'h33);
    rst = 1'b1;
    @(negedge clk);
    check("t5_vsync", 32'(vsync), 32'd0);
    check("t5_hsync", 32'(hsync), 32'd0);
    check("t5_act", 32'(act), 32'd0);
    check("t5_strobe", 32'(strobe), 32'd0);
    check("t5_pix", 32'(pix), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_line_cnt", line_cnt, 32'd0);
    check("t5_frame_cnt", frame_cnt, 32'd0);
    check("t5_stall_cnt", stall_cnt, 32'd0);
    rst = 1'b0;
    wait_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
